// File: rtl/gesture_pkg.sv
// Shared coordinate types and tracker FSM encoding for the gesture pipeline.
// Pure declarations: no latency, no flow control.
package gesture_pkg;

  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t COORD_MAX = 11'h7FF;

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } bbox_state_t;

  // Mean of two coordinates through a 12-bit sum, so 2047+2047 cannot wrap.
  function automatic coord_t coord_avg(input coord_t a, input coord_t b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COORD_W:1];
  endfunction

endpackage

// File: rtl/hand_bbox_acc.sv
// Per-hand bounding-box accumulator with snapshot/clear, midpoint and found flag.
// Snapshot registers on the frame_end edge; one pixel per clock, never stalls.
import gesture_pkg::*;

module hand_bbox_acc #(
  parameter int MIN_PIXELS = 64,
  parameter int CNT_W      = 20
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   en_i,
  input  logic   pix_i,
  input  logic   snap_i,
  input  coord_t hcount_i,
  input  coord_t vcount_i,
  output logic   found_o,
  output coord_t mid_x_o,
  output coord_t mid_y_o
);

  coord_t           min_x_q, min_x_d;
  coord_t           max_x_q, max_x_d;
  coord_t           min_y_q, min_y_d;
  coord_t           max_y_q, max_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  coord_t           snap_min_x_q, snap_max_x_q;
  coord_t           snap_min_y_q, snap_max_y_q;
  logic [CNT_W-1:0] snap_cnt_q;

  logic take;

  assign take = en_i & pix_i;

  // The _d values include the current pixel, so a pixel coinciding with the
  // snapshot still lands in the ending frame.
  always_comb begin
    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    cnt_d   = cnt_q;
    if (take) begin
      if (hcount_i < min_x_q) min_x_d = hcount_i;
      if (hcount_i > max_x_q) max_x_d = hcount_i;
      if (vcount_i < min_y_q) min_y_d = vcount_i;
      if (vcount_i > max_y_q) max_y_d = vcount_i;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      min_x_q      <= COORD_MAX;
      max_x_q      <= '0;
      min_y_q      <= COORD_MAX;
      max_y_q      <= '0;
      cnt_q        <= '0;
      snap_min_x_q <= '0;
      snap_max_x_q <= '0;
      snap_min_y_q <= '0;
      snap_max_y_q <= '0;
      snap_cnt_q   <= '0;
    end else if (snap_i) begin
      snap_min_x_q <= min_x_d;
      snap_max_x_q <= max_x_d;
      snap_min_y_q <= min_y_d;
      snap_max_y_q <= max_y_d;
      snap_cnt_q   <= cnt_d;
      min_x_q      <= COORD_MAX;
      max_x_q      <= '0;
      min_y_q      <= COORD_MAX;
      max_y_q      <= '0;
      cnt_q        <= '0;
    end else begin
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      min_y_q <= min_y_d;
      max_y_q <= max_y_d;
      cnt_q   <= cnt_d;
    end
  end

  assign found_o = (snap_cnt_q >= CNT_W'(MIN_PIXELS));
  assign mid_x_o = coord_avg(snap_min_x_q, snap_max_x_q);
  assign mid_y_o = coord_avg(snap_min_y_q, snap_max_y_q);

endmodule

// File: rtl/hand_bbox_tracker.sv
// Two-hand bbox tracker: publishes midpoints 2 clocks after frame_end; no backpressure.
// Optional HAND_SMOOTH_EN averages each found hand's new midpoint with the previous one.
import gesture_pkg::*;

module hand_bbox_tracker #(
  parameter int MIN_PIXELS = 64,
  parameter int CNT_W      = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        pixel_valid,
  input  logic        mask1,
  input  logic        mask2,
  input  logic        frame_end,
  output logic [10:0] x1,
  output logic [10:0] y1,
  output logic [10:0] x2,
  output logic [10:0] y2,
  output logic        hand1_found,
  output logic        hand2_found,
  output logic        coords_valid
);

  bbox_state_t state_q, state_d;

  logic   acc_en, snap;
  logic   found1, found2;
  coord_t mid_x1, mid_y1, mid_x2, mid_y2;

  coord_t x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
  logic   f1_q, f1_d, f2_q, f2_d, cv_q, cv_d;

  // Pixels in the PUBLISH cycle already belong to the next frame.
  assign acc_en = (state_q != SYNC);
  assign snap   = (state_q == ACCUM) && frame_end;

  hand_bbox_acc #(.MIN_PIXELS(MIN_PIXELS), .CNT_W(CNT_W)) u_acc1 (
    .clock    (clock),
    .reset    (reset),
    .en_i     (acc_en),
    .pix_i    (pixel_valid & mask1),
    .snap_i   (snap),
    .hcount_i (hcount),
    .vcount_i (vcount),
    .found_o  (found1),
    .mid_x_o  (mid_x1),
    .mid_y_o  (mid_y1)
  );

  hand_bbox_acc #(.MIN_PIXELS(MIN_PIXELS), .CNT_W(CNT_W)) u_acc2 (
    .clock    (clock),
    .reset    (reset),
    .en_i     (acc_en),
    .pix_i    (pixel_valid & mask2),
    .snap_i   (snap),
    .hcount_i (hcount),
    .vcount_i (vcount),
    .found_o  (found2),
    .mid_x_o  (mid_x2),
    .mid_y_o  (mid_y2)
  );

  function automatic coord_t next_coord(input coord_t prev, input coord_t fresh,
                                        input logic prev_found);
`ifdef HAND_SMOOTH_EN
    return prev_found ? coord_avg(prev, fresh) : fresh;
`else
    return (prev_found & 1'b0) ? prev : fresh;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:    if (frame_end) state_d = ACCUM;
      ACCUM:   if (frame_end) state_d = PUBLISH;
      PUBLISH: state_d = ACCUM;
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    x1_d = x1_q;
    y1_d = y1_q;
    x2_d = x2_q;
    y2_d = y2_q;
    f1_d = f1_q;
    f2_d = f2_q;
    cv_d = 1'b0;
    if (state_q == PUBLISH) begin
      cv_d = 1'b1;
      f1_d = found1;
      f2_d = found2;
      if (found1) begin
        x1_d = next_coord(x1_q, mid_x1, f1_q);
        y1_d = next_coord(y1_q, mid_y1, f1_q);
      end
      if (found2) begin
        x2_d = next_coord(x2_q, mid_x2, f2_q);
        y2_d = next_coord(y2_q, mid_y2, f2_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SYNC;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      f1_q    <= 1'b0;
      f2_q    <= 1'b0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      cv_q    <= cv_d;
    end
  end

  assign x1           = x1_q;
  assign y1           = y1_q;
  assign x2           = x2_q;
  assign y2           = y2_q;
  assign hand1_found  = f1_q;
  assign hand2_found  = f2_q;
  assign coords_valid = cv_q;

endmodule

// File: tb/tb_hand_bbox_tracker.sv
// Directed bench for hand_bbox_tracker: frame-level pixel-list model plus literal pins.
module tb_hand_bbox_tracker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [10:0] vcount = '0;
  logic        pixel_valid = 1'b0;
  logic        mask1 = 1'b0;
  logic        mask2 = 1'b0;
  logic        frame_end = 1'b0;
  logic [10:0] x1, y1, x2, y2;
  logic        hand1_found, hand2_found, coords_valid;

  always #5 clock = ~clock;

  hand_bbox_tracker #(.MIN_PIXELS(64), .CNT_W(20)) dut (
    .clock        (clock),
    .reset        (reset),
    .hcount       (hcount),
    .vcount       (vcount),
    .pixel_valid  (pixel_valid),
    .mask1        (mask1),
    .mask2        (mask2),
    .frame_end    (frame_end),
    .x1           (x1),
    .y1           (y1),
    .x2           (x2),
    .y2           (y2),
    .hand1_found  (hand1_found),
    .hand2_found  (hand2_found),
    .coords_valid (coords_valid)
  );

`ifdef HAND_SMOOTH_EN
  localparam int EXP_X1_PUBPIX = 1025;
  localparam int EXP_X1_200    = 160;
  localparam bit SMOOTH        = 1'b1;
`else
  localparam int EXP_X1_PUBPIX = 5;
  localparam int EXP_X1_200    = 200;
  localparam bit SMOOTH        = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Expected outputs, updated once per clock edge from the frame model.
  int e_x1, e_y1, e_x2, e_y2;
  bit e_f1, e_f2, e_cv;

  // Frame model: synced flag, in-progress pixel lists, one pending publish.
  bit synced, in_pub, pub_pend;
  int q1x[$], q1y[$], q2x[$], q2y[$];
  bit p_f1, p_f2;
  int p_x1, p_y1, p_x2, p_y2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qmin(input int q[$]);
    int m = 2047;
    foreach (q[i]) if (q[i] < m) m = q[i];
    return m;
  endfunction

  function automatic int qmax(input int q[$]);
    int m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  function automatic int upd(input int prev, input int fresh, input bit prev_found);
    if (SMOOTH && prev_found) return (prev + fresh) / 2;
    return fresh;
  endfunction

  task automatic model_step(input bit rst, input bit pv, input bit m1, input bit m2,
                            input int h, input int v, input bit fe);
    if (rst) begin
      {e_x1, e_y1, e_x2, e_y2} = '0;
      {e_f1, e_f2, e_cv} = '0;
      synced = 0; in_pub = 0; pub_pend = 0;
      q1x.delete(); q1y.delete(); q2x.delete(); q2y.delete();
      return;
    end
    e_cv = 1'b0;
    if (pub_pend) begin
      e_cv = 1'b1;
      if (p_f1) begin
        e_x1 = upd(e_x1, p_x1, e_f1);
        e_y1 = upd(e_y1, p_y1, e_f1);
      end
      if (p_f2) begin
        e_x2 = upd(e_x2, p_x2, e_f2);
        e_y2 = upd(e_y2, p_y2, e_f2);
      end
      e_f1 = p_f1;
      e_f2 = p_f2;
      pub_pend = 0;
    end
    if (synced && pv) begin
      if (m1) begin q1x.push_back(h); q1y.push_back(v); end
      if (m2) begin q2x.push_back(h); q2y.push_back(v); end
    end
    if (in_pub) begin
      in_pub = 0;
    end else if (fe) begin
      if (!synced) begin
        synced = 1;
      end else begin
        p_f1 = (q1x.size() >= 64);
        p_f2 = (q2x.size() >= 64);
        p_x1 = (qmin(q1x) + qmax(q1x)) / 2;
        p_y1 = (qmin(q1y) + qmax(q1y)) / 2;
        p_x2 = (qmin(q2x) + qmax(q2x)) / 2;
        p_y2 = (qmin(q2y) + qmax(q2y)) / 2;
        q1x.delete(); q1y.delete(); q2x.delete(); q2y.delete();
        pub_pend = 1;
        in_pub = 1;
      end
    end
  endtask

  task automatic cyc(input bit rst, input bit pv, input bit m1, input bit m2,
                     input int h, input int v, input bit fe);
    reset = rst; pixel_valid = pv; mask1 = m1; mask2 = m2;
    hcount = h[10:0]; vcount = v[10:0]; frame_end = fe;
    @(posedge clock);
    model_step(rst, pv, m1, m2, h, v, fe);
    #1;
  endtask

  task automatic pix(input bit m1, input bit m2, input int h, input int v);
    cyc(0, 1, m1, m2, h, v, 0);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fend();
    cyc(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic rect(input bit m1, input bit m2, input int xa, input int xb,
                      input int ya, input int yb);
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++)
        pix(m1, m2, x, y);
  endtask

  // Frame end then the PUBLISH cycle, landing in the coords_valid cycle.
  task automatic publish();
    fend();
    idle();
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("cmp_coords_valid", coords_valid, e_cv);
      check("cmp_hand1_found", hand1_found, e_f1);
      check("cmp_hand2_found", hand2_found, e_f2);
      check("cmp_x1", x1, e_x1);
      check("cmp_y1", y1, e_y1);
      check("cmp_x2", x2, e_x2);
      check("cmp_y2", y2, e_y2);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    @(negedge clock);
    check("rst_x1", x1, 0);
    check("rst_found1", hand1_found, 0);
    check("rst_cv", coords_valid, 0);

    // First frame after reset is discarded.
    rect(1, 0, 100, 140, 200, 220);
    publish();
    check("sync_no_cv", coords_valid, 0);

    rect(1, 0, 100, 140, 200, 220);
    publish();
    check("a_cv", coords_valid, 1);
    check("a_x1", x1, 120);
    check("a_y1", y1, 210);
    check("a_f1", hand1_found, 1);
    check("a_f2", hand2_found, 0);
    check("a_x2", x2, 0);
    check("a_y2", y2, 0);

    // Hand 2 one pixel short, then exactly at threshold.
    rect(0, 1, 300, 308, 50, 56);
    publish();
    check("h2_63_f2", hand2_found, 0);
    check("h2_63_x2", x2, 0);
    check("h2_63_x1_hold", x1, 120);
    check("h2_63_f1", hand1_found, 0);
    rect(0, 1, 300, 308, 50, 56);
    pix(0, 1, 310, 60);
    publish();
    check("h2_64_f2", hand2_found, 1);
    check("h2_64_x2", x2, 305);
    check("h2_64_y2", y2, 55);

    // Pixel with frame_end belongs to the ending frame; midpoint must not wrap.
    repeat (62) pix(1, 0, 2046, 2046);
    pix(1, 0, 2045, 2045);
    cyc(0, 1, 1, 0, 2047, 2047, 1);
    pix(1, 0, 5, 5);
    @(negedge clock);
    check("edge_cv", coords_valid, 1);
    check("edge_f1", hand1_found, 1);
    check("edge_x1", x1, 2046);
    check("edge_y1", y1, 2046);

    // The PUBLISH-cycle pixel above is the 64th pixel of this frame.
    repeat (63) pix(1, 0, 5, 5);
    publish();
    check("pubpix_f1", hand1_found, 1);
    check("pubpix_x1", x1, EXP_X1_PUBPIX);

    // Smoothing sequence: not found, 120, 200, not found, 40.
    publish();
    check("sm_nf_f1", hand1_found, 0);
    rect(1, 0, 100, 140, 200, 220);
    publish();
    check("sm_120", x1, 120);
    rect(1, 0, 180, 220, 200, 220);
    publish();
    check("sm_200", x1, EXP_X1_200);
    check("sm_200_y1", y1, 210);
    publish();
    check("sm_nf2_f1", hand1_found, 0);
    rect(1, 0, 20, 60, 200, 220);
    publish();
    check("sm_40", x1, 40);

    // Reset mid-frame, then the next frame_end only syncs.
    rect(1, 1, 10, 30, 10, 12);
    cyc(1, 1, 1, 1, 15, 15, 0);
    @(negedge clock);
    check("mid_rst_x1", x1, 0);
    check("mid_rst_x2", x2, 0);
    check("mid_rst_f2", hand2_found, 0);
    publish();
    check("mid_rst_sync_cv", coords_valid, 0);
    publish();
    check("post_rst_cv", coords_valid, 1);
    check("post_rst_f1", hand1_found, 0);

    idle();
    @(negedge clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
